iobus_uart_tx: RTL

- Memory-mapped UART transmitter that responds to the OTTER MCU's IOBUS write/read transactions.
- Serializes bytes written by the CPU onto an 8N1 TX line, mirroring the programmer's serial receive path in the opposite direction.
- Buffers CPU writes in a small FIFO so firmware can post several bytes without polling.
- Exposes a status word that the top level ORs into IOBUS_IN.

---
 rtl/iobus_uart_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: CPU byte writes are queued in a small FIFO
// and shifted out LSB first; a STATUS word reports FIFO and line state.
module iobus_uart_tx #(
  parameter int          CLK_RATE   = 50,
  parameter int          BAUD       = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0040,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_RD,
  output logic        TX,
  output logic        TX_BUSY
);

  function automatic int round_div(input int num, input int den);
    return (num + den / 2) / den;
  endfunction

  localparam int DATA_W = 8;
  localparam int DIV    = round_div(CLK_RATE * 1_000_000, BAUD);
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [31:0]      STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              overflow, full, empty;
  logic              wr_data, wr_stat, push, pop;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic [DATA_W-1:0] shift;
  logic              shift_en, tx_nxt, bit_end;

  logic              unused_hi;
  assign unused_hi = ^IOBUS_OUT[31:8];

  assign full    = (count == LVL_FULL);
  assign empty   = (count == '0);
  assign wr_data = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
  assign wr_stat = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = wr_data && (!full || pop);
  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + LVL_ONE;
      else if (!push && pop) count <= count - LVL_ONE;
      if (wr_data && full && !pop) overflow <= 1'b1;
      else if (wr_stat)            overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= IOBUS_OUT[DATA_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (pop)           shift <= mem[rd_ptr];
    else if (shift_en) shift <= shift >> 1;
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + CNT_ONE;
    bit_nxt   = bit_idx;
    pop       = 1'b0;
    shift_en  = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        tx_nxt = shift[0];
        if (bit_end) begin
          baud_nxt = '0;
          shift_en = 1'b1;
          bit_nxt  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // TX is driven from the current state, so the line lags the state by one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      TX       <= 1'b1;
      TX_BUSY  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      TX       <= tx_nxt;
      TX_BUSY  <= (state != IDLE) || !empty;
    end
  end

  always_comb begin
    IOBUS_RD = '0;
    if (IOBUS_ADDR == STAT_ADDR) begin
      IOBUS_RD[0]    = full;
      IOBUS_RD[1]    = empty;
      IOBUS_RD[2]    = TX_BUSY;
      IOBUS_RD[3]    = overflow;
      IOBUS_RD[12:8] = 5'(count);
    end
  end

endmodule
